// File: rtl/fpn_mult.sv
// Parametrised floating-point multiplier with a shift-add multi-cycle datapath.
// Subnormal inputs and results are flushed to zero. Latency is fixed at
// MAN_W+5 cycles from the start edge to the end of the done pulse, and it is
// the same for every operand class and rounding mode.
module fpn_mult #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [1:0]             rnd_mode,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   p,
  output logic [3:0]             flags
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SW    = MAN_W + 1;        // significand width including hidden 1
  localparam int PW    = 2 * SW;           // full product width
  localparam int XW    = EXP_W + 2;        // signed working exponent width
  localparam int CNT_W = $clog2(SW);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(MAN_W);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX    = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] XZERO   = '0;
  localparam logic signed [XW-1:0] XONE    = XW'(1);
  localparam logic [EXP_W-1:0]    EXP_ONES = '1;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [W-1:0]           a_reg, b_reg, p_reg;
  logic [1:0]             rm_reg;
  logic [3:0]             flags_reg;
  logic                   sign_reg, sp_nan_reg, sp_inv_reg, sp_inf_reg, sp_zero_reg;
  logic [SW-1:0]          ma_reg;
  logic [PW-1:0]          prod_reg;     // {accumulator, shifting multiplier}
  logic signed [XW-1:0]   exp_reg;
  logic [CNT_W-1:0]       cnt_reg;

  // Operand classification from the captured operands
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic signed [XW-1:0] exp_sum;

  assign ea     = a_reg[W-2:MAN_W];
  assign eb     = b_reg[W-2:MAN_W];
  assign fa     = a_reg[MAN_W-1:0];
  assign fb     = b_reg[MAN_W-1:0];
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);               // zero and subnormal both count as zero
  assign b_zero = ~(|eb);
  assign exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

  // One shift-add step: add the multiplicand when the multiplier LSB is set
  logic [SW:0]   add_sum;
  logic [PW-1:0] prod_step;
  assign add_sum   = {1'b0, prod_reg[PW-1:SW]} + (prod_reg[0] ? {1'b0, ma_reg} : '0);
  assign prod_step = {add_sum, prod_reg[SW-1:1]};

  // Rounding of the normalised product (leading 1 sits at PW-2)
  logic                 guard, sticky, round_up, carry, overflow, underflow, to_max;
  logic [MAN_W:0]       fsum;
  logic signed [XW-1:0] exp_fin;
  logic [W-1:0]         res_p;
  logic [3:0]           res_flags;

  assign guard  = prod_reg[MAN_W-1];
  assign sticky = |prod_reg[MAN_W-2:0];

  // Rounding decision and result selection, specials override the datapath
  always_comb begin
    round_up = 1'b0;
    case (rm_reg)
      2'd0:    round_up = guard & (sticky | prod_reg[MAN_W]);
      2'd1:    round_up = 1'b0;
      2'd2:    round_up = (guard | sticky) & ~sign_reg;
      default: round_up = (guard | sticky) & sign_reg;
    endcase
    fsum      = {1'b0, prod_reg[PW-3:MAN_W]} + {{MAN_W{1'b0}}, round_up};
    carry     = fsum[MAN_W];
    exp_fin   = carry ? exp_reg + XONE : exp_reg;
    overflow  = (exp_fin >= EMAX);
    underflow = (exp_fin <= XZERO);
    to_max    = (rm_reg == 2'd1) | ((rm_reg == 2'd2) & sign_reg) | ((rm_reg == 2'd3) & ~sign_reg);
    res_p     = {sign_reg, exp_fin[EXP_W-1:0], fsum[MAN_W-1:0]};
    res_flags = {3'b000, guard | sticky};
    if (sp_nan_reg) begin
      res_p     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
      res_flags = {sp_inv_reg, 3'b000};
    end else if (sp_inf_reg) begin
      res_p     = {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
      res_flags = 4'b0000;
    end else if (sp_zero_reg) begin
      res_p     = {sign_reg, {(W-1){1'b0}}};
      res_flags = 4'b0000;
    end else if (overflow) begin
      res_p     = to_max ? {sign_reg, EXP_ONES - 1'b1, {MAN_W{1'b1}}}
                         : {sign_reg, EXP_ONES, {MAN_W{1'b0}}};
      res_flags = 4'b0101;
    end else if (underflow) begin
      res_p     = {sign_reg, {(W-1){1'b0}}};
      res_flags = 4'b0011;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs; DONE can accept a new start directly
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_UNPACK;
      end
      S_UNPACK: state_next = S_MULT;
      S_MULT:   if (cnt_reg == CNT_LAST) state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = start ? S_UNPACK : S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath: capture, unpack, shift-add, normalise, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg     <= '0;
      flags_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            rm_reg <= rnd_mode;
          end
        end
        S_UNPACK: begin
          sign_reg    <= a_reg[W-1] ^ b_reg[W-1];
          sp_nan_reg  <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
          sp_inv_reg  <= a_snan | b_snan | (a_inf & b_zero) | (a_zero & b_inf);
          sp_inf_reg  <= a_inf | b_inf;
          sp_zero_reg <= a_zero | b_zero;
          ma_reg      <= {1'b1, fa};
          prod_reg    <= {{SW{1'b0}}, 1'b1, fb};
          exp_reg     <= exp_sum;
          cnt_reg     <= '0;
        end
        S_MULT: begin
          prod_reg <= prod_step;
          cnt_reg  <= cnt_reg + 1'b1;
        end
        S_NORM: begin
          // The dropped LSB is jammed into bit 0 so it still feeds sticky
          if (prod_reg[PW-1]) begin
            prod_reg <= {1'b0, prod_reg[PW-1:2], prod_reg[1] | prod_reg[0]};
            exp_reg  <= exp_reg + XONE;
          end
        end
        S_ROUND: begin
          p_reg     <= res_p;
          flags_reg <= res_flags;
        end
        default: ;
      endcase
    end
  end

  assign p     = p_reg;
  assign flags = flags_reg;

endmodule

// File: tb/tb_fpn_mult.sv
// Scoreboard bench for fpn_mult: binary32 and a 5/10 half-size instance.
module tb_fpn_mult;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a32, b32, p32;
  logic [15:0] a16, b16, p16;
  logic [1:0]  rm32, rm16;
  logic        start32, busy32, done32, start16, busy16, done16;
  logic [3:0]  fl32, fl16;

  fpn_mult #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .rnd_mode(rm32), .start(start32),
    .busy(busy32), .done(done32), .p(p32), .flags(fl32));

  fpn_mult #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .rnd_mode(rm16), .start(start16),
    .busy(busy16), .done(done16), .p(p16), .flags(fl16));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a, b, p;
    logic [1:0]  rm;
    logic [3:0]  fl;
    int unsigned due;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  int checks = 0;
  int passes = 0;
  logic [31:0] last_p32 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // Reference: exact integer product, rounded by comparing the remainder to half an ulp
  function automatic void model(input int ew, input int mw, input logic [31:0] a,
                                input logic [31:0] b, input logic [1:0] rm,
                                output logic [31:0] p, output logic [3:0] fl);
    longint unsigned one, emax, mmask, ea, eb, fa, fb, prod, q, rem, half, r;
    longint e, bias;
    int L, sh;
    bit sg, na, nb, sna, snb, ia, ib, za, zb, up, inx, tomax;
    one   = 1;
    emax  = (one << ew) - 1;
    mmask = (one << mw) - 1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    ea = (longint'(a) >> mw) & emax;  fa = longint'(a) & mmask;
    eb = (longint'(b) >> mw) & emax;  fb = longint'(b) & mmask;
    sg  = a[ew+mw] ^ b[ew+mw];
    na  = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
    sna = na && (((fa >> (mw-1)) & 1) == 0);
    snb = nb && (((fb >> (mw-1)) & 1) == 0);
    ia  = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
    za  = (ea == 0);                  zb = (eb == 0);
    r  = 0;
    fl = 4'b0000;
    if (na || nb || (ia && zb) || (za && ib)) begin
      r  = (emax << mw) | (one << (mw - 1));
      fl = {sna || snb || (ia && zb) || (za && ib), 3'b000};
    end else if (ia || ib) begin
      r = (longint'(sg) << (ew + mw)) | (emax << mw);
    end else if (za || zb) begin
      r = longint'(sg) << (ew + mw);
    end else begin
      prod = ((one << mw) | fa) * ((one << mw) | fb);
      L    = (((prod >> (2*mw + 1)) & 1) != 0) ? 2*mw + 1 : 2*mw;
      sh   = L - mw;
      q    = prod >> sh;
      rem  = prod & ((one << sh) - 1);
      half = one << (sh - 1);
      inx  = (rem != 0);
      case (rm)
        2'd0:    up = (rem > half) || ((rem == half) && ((q & 1) != 0));
        2'd1:    up = 1'b0;
        2'd2:    up = inx && !sg;
        default: up = inx && sg;
      endcase
      q = q + longint'(up);
      e = longint'(ea) + longint'(eb) - bias + longint'(L - 2*mw);
      if ((q >> (mw + 1)) != 0) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= longint'(emax)) begin
        tomax = (rm == 2'd1) || ((rm == 2'd2) && sg) || ((rm == 2'd3) && !sg);
        r  = (longint'(sg) << (ew + mw)) | (tomax ? (((emax - 1) << mw) | mmask) : (emax << mw));
        fl = 4'b0101;
      end else if (e <= 0) begin
        r  = longint'(sg) << (ew + mw);
        fl = 4'b0011;
      end else begin
        r  = (longint'(sg) << (ew + mw)) | (longint'(e) << mw) | (q & mmask);
        fl = {3'b000, inx};
      end
    end
    p = r[31:0];
  endfunction

  // Issue one operation; expected values come from the table when given, else the model
  task automatic issue(input bit wide, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] rm, input bit use_req,
                       input logic [31:0] req_p, input logic [3:0] req_fl);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while ((wide ? busy32 : busy16) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL busy_timeout actual=busy_after_%0d_cycles required=idle", n);
    end
    e.a = a; e.b = b; e.rm = rm;
    if (use_req) begin
      e.p = req_p; e.fl = req_fl;
    end else if (wide) model(8, 23, a, b, rm, e.p, e.fl);
    else               model(5, 10, a, b, rm, e.p, e.fl);
    if (wide) begin
      e.due = cyc + 28;
      a32 = a; b32 = b; rm32 = rm; start32 = 1'b1;
      q32.push_back(e);
      last_p32 = e.p;
    end else begin
      e.due = cyc + 15;
      a16 = a[15:0]; b16 = b[15:0]; rm16 = rm; start16 = 1'b1;
      q16.push_back(e);
    end
    @(negedge clk);
    start32 = 1'b0;
    start16 = 1'b0;
    // Scramble inputs: the operation in flight must not see this
    a32 = $urandom; b32 = $urandom; rm32 = 2'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); rm16 = 2'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q32.size() + q16.size());
    end
  endtask

  function automatic logic [31:0] rand_op32();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v[30:23] = 8'($urandom_range(1, 20));
      3: v[30:23] = 8'($urandom_range(235, 254));
      4: v[22:0]  = v[22:0] & 23'h7FF000;
      default: ;
    endcase
    return v;
  endfunction

  // Monitor for the binary32 instance
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && done32) begin
      if (q32.size() == 0) begin
        checks++;
        $display("FAIL extra_done32 actual=done required=no_done p=%h", p32);
      end else begin
        e = q32.pop_front();
        $display("txn32 a=%h b=%h rm=%0d p=%h flags=%b expect p=%h flags=%b",
                 e.a, e.b, e.rm, p32, fl32, e.p, e.fl);
        check("p32", p32, e.p);
        check("flags32", {28'd0, fl32}, {28'd0, e.fl});
        check("latency32", cyc, e.due);
      end
    end
  end

  // Monitor for the half-size instance
  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst && done16) begin
      if (q16.size() == 0) begin
        checks++;
        $display("FAIL extra_done16 actual=done required=no_done p=%h", p16);
      end else begin
        e = q16.pop_front();
        $display("txn16 a=%h b=%h rm=%0d p=%h flags=%b expect p=%h flags=%b",
                 e.a[15:0], e.b[15:0], e.rm, p16, fl16, e.p[15:0], e.fl);
        check("p16", {16'd0, p16}, e.p);
        check("flags16", {28'd0, fl16}, {28'd0, e.fl});
        check("latency16", cyc, e.due);
      end
    end
  end

  localparam int ND = 16;
  logic [31:0] da [ND] = '{32'h40200000, 32'h41720000, 32'h3F800001, 32'h3F800001,
                           32'h3F800001, 32'hC0000000, 32'h7F000000, 32'h7F000000,
                           32'h00800000, 32'h7F800000, 32'hFF800000, 32'hFF000000,
                           32'hFF000000, 32'h7F800001, 32'h7FC00001, 32'h3F800001};
  logic [31:0] db [ND] = '{32'h40E00000, 32'h42044000, 32'h3F800001, 32'h3F800001,
                           32'h3F800001, 32'h40400000, 32'h7F000000, 32'h7F000000,
                           32'h3F000000, 32'h00000000, 32'h40000000, 32'h7F000000,
                           32'h7F000000, 32'h3F800000, 32'h00000000, 32'hBF800001};
  logic [1:0]  dr [ND] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1,
                           2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3};
  logic [31:0] dp [ND] = '{32'h418C0000, 32'h43FA0900, 32'h3F800002, 32'h3F800002,
                           32'h3F800003, 32'hC0C00000, 32'h7F800000, 32'h7F7FFFFF,
                           32'h00000000, 32'h7FC00000, 32'hFF800000, 32'hFF800000,
                           32'hFF7FFFFF, 32'h7FC00000, 32'h7FC00000, 32'hBF800003};
  logic [3:0]  df [ND] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0101, 4'b0101,
                           4'b0011, 4'b1000, 4'b0000, 4'b0101, 4'b0101, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst = 1'b1;
    start32 = 1'b0; start16 = 1'b0;
    a32 = '0; b32 = '0; rm32 = '0; a16 = '0; b16 = '0; rm16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy32",  {31'd0, busy32}, 32'd0);
    check("rst_done32",  {31'd0, done32}, 32'd0);
    check("rst_p32",     p32, 32'd0);
    check("rst_flags32", {28'd0, fl32}, 32'd0);
    check("rst_p16",     {16'd0, p16}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < ND; i++) issue(1'b1, da[i], db[i], dr[i], 1'b1, dp[i], df[i]);
    issue(1'b0, 32'h4000, 32'h4200, 2'd0, 1'b1, 32'h4600, 4'b0000);
    wait_idle();

    // start while busy is ignored and p holds the previous result
    issue(1'b1, 32'h40200000, 32'h40E00000, 2'd0, 1'b1, 32'h418C0000, 4'b0000);
    repeat (3) @(negedge clk);
    a32 = 32'h3F800000; b32 = 32'h3F800000; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    check("busy_during_op", {31'd0, busy32}, 32'd1);
    check("p_held", p32, 32'hBF800003);
    wait_idle();
    repeat (40) @(negedge clk);

    // reset in the middle of an operation
    issue(1'b1, 32'h41720000, 32'h42044000, 2'd0, 1'b1, 32'h43FA0900, 4'b0000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q32.delete();
    @(negedge clk);
    check("midrst_p32",     p32, 32'd0);
    check("midrst_busy32",  {31'd0, busy32}, 32'd0);
    check("midrst_done32",  {31'd0, done32}, 32'd0);
    check("midrst_flags32", {28'd0, fl32}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // randomised traffic against the reference model
    for (int i = 0; i < 250; i++) issue(1'b1, rand_op32(), rand_op32(), 2'($urandom), 1'b0, '0, '0);
    for (int i = 0; i < 120; i++) issue(1'b0, {16'd0, 16'($urandom)}, {16'd0, 16'($urandom)},
                                        2'($urandom), 1'b0, '0, '0);
    wait_idle();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
